// File: rtl/actel_cfg_loader.sv
// Serial configuration loader for C2/S-type logic cells: shifts a payload into a shadow
// register, checks even parity, then commits atomically. Optional readback under READBACK_EN.
module actel_cfg_loader #(
  parameter int NUM_CELLS     = 8,
  parameter int BITS_PER_CELL = 4
) (
  input  logic                               clk,
  input  logic                               clr,
  input  logic                               start,
  input  logic                               sin_valid,
  input  logic                               sin_data,
  output logic                               sin_ready,
  output logic                               busy,
  output logic [NUM_CELLS*BITS_PER_CELL-1:0] cfg_d,
  output logic                               cfg_done,
  output logic                               cfg_err,
  input  logic                               rb_req,
  output logic                               rb_valid,
  output logic                               rb_data
);

  localparam int CFG_W = NUM_CELLS * BITS_PER_CELL;
  localparam int CNT_W = (CFG_W > 1) ? $clog2(CFG_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CFG_W - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    PARITY = 2'd2,
    RDBK   = 2'd3
  } state_e;

  state_e             state_q, state_d;
  logic [CFG_W-1:0]   shadow_q, shadow_d;
  logic [CFG_W-1:0]   active_q, active_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               par_q, par_d;
  logic               done_q, done_d;
  logic               err_q, err_d;
  logic               xfer;

  assign sin_ready = (state_q == SHIFT) || (state_q == PARITY);
  assign busy      = sin_ready;
  assign xfer      = sin_valid && sin_ready;
  assign cfg_d     = active_q;
  assign cfg_done  = done_q;
  assign cfg_err   = err_q;

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    active_d = active_q;
    cnt_d    = cnt_q;
    par_d    = par_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        par_d = 1'b0;
        if (start) begin
          state_d = SHIFT;
`ifdef READBACK_EN
        end else if (rb_req) begin
          state_d = RDBK;
`endif
        end
      end
      SHIFT: begin
        if (xfer) begin
          shadow_d[cnt_q] = sin_data;
          par_d           = par_q ^ sin_data;
          // Counter holds at the last index rather than wrapping.
          if (cnt_q == CNT_LAST) begin
            state_d = PARITY;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      PARITY: begin
        if (xfer) begin
          state_d = IDLE;
          if (sin_data == par_q) begin
            active_d = shadow_q;
            done_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
`ifdef READBACK_EN
      RDBK: begin
        if (cnt_q == CNT_LAST) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the shadow is reset along with the rest; it is small flop storage, not a RAM.
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q  <= IDLE;
      shadow_q <= '0;
      active_q <= '0;
      cnt_q    <= '0;
      par_q    <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so all flops update from pre-edge values.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      active_q <= active_d;
      cnt_q    <= cnt_d;
      par_q    <= par_d;
      done_q   <= done_d;
      err_q    <= err_d;
    end
  end

`ifdef READBACK_EN
  assign rb_valid = (state_q == RDBK);
  assign rb_data  = (state_q == RDBK) && active_q[cnt_q];
`else
  logic unused_rb_req;
  assign unused_rb_req = rb_req;
  assign rb_valid      = 1'b0;
  assign rb_data       = 1'b0;
`endif

endmodule

// File: tb/tb_actel_cfg_loader.sv
// Scoreboard bench for actel_cfg_loader (CFG_W=8): stimulus pushes expected commit/error
// events and readback bits; a negedge monitor pops and compares whenever the DUT presents them.
module tb_actel_cfg_loader;

  localparam int CFG_W = 8;

  logic             clk = 1'b0;
  logic             clr, start, sin_valid, sin_data, rb_req;
  logic             sin_ready, busy, cfg_done, cfg_err, rb_valid, rb_data;
  logic [CFG_W-1:0] cfg_d;

  typedef struct packed {
    logic             done;
    logic             err;
    logic [CFG_W-1:0] cfg;
  } exp_t;

  exp_t             sb_q[$];
  logic             rb_q[$];
  logic [CFG_W-1:0] model_cfg;
  logic             prev_ev = 1'b0;
  int               n_checks = 0;
  int               n_pass = 0;

  always #5 clk = ~clk;

  actel_cfg_loader #(.NUM_CELLS(2), .BITS_PER_CELL(4)) dut (
    .clk(clk), .clr(clr), .start(start),
    .sin_valid(sin_valid), .sin_data(sin_data), .sin_ready(sin_ready),
    .busy(busy), .cfg_d(cfg_d), .cfg_done(cfg_done), .cfg_err(cfg_err),
    .rb_req(rb_req), .rb_valid(rb_valid), .rb_data(rb_data)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: compares DUT events against the scoreboard queues.
  always @(negedge clk) begin
    exp_t e;
    logic b;
    if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
      check("pulse_width", prev_ev, 0);
      check("sb_pending", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        check("sb_done", cfg_done, e.done);
        check("sb_err", cfg_err, e.err);
        check("sb_cfg_d", cfg_d, e.cfg);
      end
    end
    prev_ev = (cfg_done === 1'b1) || (cfg_err === 1'b1);
    if (rb_valid === 1'b1) begin
      check("rb_pending", rb_q.size() > 0, 1);
      if (rb_q.size() > 0) begin
        b = rb_q.pop_front();
        check("rb_data", rb_data, b);
      end
    end
  end

  // Called at a negedge; returns at the negedge following the transfer edge.
  task automatic send_bit(input logic b, input logic poke_start);
    int n = 0;
    while (sin_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("ready_timeout", sin_ready, 1);
    sin_valid = 1'b1;
    sin_data  = b;
    start     = poke_start;
    @(negedge clk);
    sin_valid = 1'b0;
    start     = 1'b0;
  endtask

  task automatic load(input logic [CFG_W-1:0] p, input logic par, input logic exp_ok,
                      input int gap, input int poke_at);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_after_start", busy, 1);
    for (int k = 0; k < CFG_W; k++) begin
      send_bit(p[k], k == poke_at);
      for (int g = 0; g < gap; g++) begin
        check("ready_in_stall", sin_ready, 1);
        @(negedge clk);
      end
    end
    if (exp_ok) begin
      model_cfg = p;
      sb_q.push_back({1'b1, 1'b0, p});
    end else begin
      sb_q.push_back({1'b0, 1'b1, model_cfg});
    end
    send_bit(par, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [CFG_W-1:0] rb_exp;
    clr = 1'b1; start = 1'b0; sin_valid = 1'b0; sin_data = 1'b0; rb_req = 1'b0;
    model_cfg = '0;
    repeat (2) @(negedge clk);
    check("rst_cfg_d", cfg_d, 0);
    check("rst_busy", busy, 0);
    check("rst_ready", sin_ready, 0);
    check("rst_done", cfg_done, 0);
    check("rst_err", cfg_err, 0);
    check("rst_rb_valid", rb_valid, 0);
    check("rst_rb_data", rb_data, 0);
    clr = 1'b0;
    @(negedge clk);

    // Good load 0xA5, even parity 0; cfg_done exactly 10 cycles after start.
    load(8'hA5, 1'b0, 1'b1, 0, -1);
    check("good_done_latency", cfg_done, 1);
    check("good_err_low", cfg_err, 0);
    check("good_cfg_d", cfg_d, 8'hA5);
    @(negedge clk);
    check("good_done_drop", cfg_done, 0);
    check("good_busy_low", busy, 0);
    check("good_cfg_hold", cfg_d, 8'hA5);

    // Readback of 0xA5: bits 1,0,1,0,0,1,0,1 LSB first (no bits expected without the macro).
    rb_exp = 8'b1010_0101;
    rb_req = 1'b1;
`ifdef READBACK_EN
    for (int k = 0; k < CFG_W; k++) rb_q.push_back(rb_exp[k]);
`endif
    @(negedge clk);
    rb_req = 1'b0;
    repeat (CFG_W) @(negedge clk);
    check("rb_valid_after", rb_valid, 0);
    check("rb_all_seen", rb_q.size(), 0);
    check("rb_busy_low", busy, 0);

    // Bad parity: 0x3C with check bit 1 -> error, cfg_d unchanged.
    load(8'h3C, 1'b1, 1'b0, 0, -1);
    check("bad_err", cfg_err, 1);
    check("bad_done_low", cfg_done, 0);
    check("bad_cfg_hold", cfg_d, 8'hA5);

    // Start in the cfg_err cycle is accepted; stalled load of 0xFF.
    load(8'hFF, 1'b0, 1'b1, 1, -1);
    @(negedge clk);
    check("stall_cfg_d", cfg_d, 8'hFF);

    // Reset after 3 accepted bits discards the partial payload.
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b0);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    model_cfg = '0;
    check("midrst_busy", busy, 0);
    check("midrst_ready", sin_ready, 0);
    check("midrst_cfg_d", cfg_d, 0);
    load(8'h5A, 1'b0, 1'b1, 0, -1);
    @(negedge clk);
    check("after_rst_cfg_d", cfg_d, 8'h5A);

    // start pulsed during SHIFT is ignored; payload 0xC3 still commits.
    load(8'hC3, 1'b0, 1'b1, 0, 3);
    @(negedge clk);
    check("busy_start_cfg_d", cfg_d, 8'hC3);
    check("busy_start_idle", busy, 0);

    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/actel_cfg_loader.md
Name: actel_cfg_loader

Overview:
- Configuration writer for an array of mux-based logic cells of the C2/S-type, each with a 4-bit D input.
- Accepts a serial configuration bitstream over a valid/ready handshake and assembles it in a shadow register.
- Checks an even-parity bit and, on success, commits the shadow register atomically to the active configuration bus that drives the cells' D inputs.
- Sits between the board-level programming interface and the logic-cell array.

Parameters:
- NUM_CELLS, 8, number of logic cells configured.
- BITS_PER_CELL, 4, D bits per cell.
- CFG_W (localparam), NUM_CELLS*BITS_PER_CELL, total payload bits. Cell i takes cfg_d[BITS_PER_CELL*i +: BITS_PER_CELL].

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- clr  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to begin a load; honoured only in IDLE.
- sin_valid  input  1  serial bit valid.
- sin_data  input  1  serial bit, LSB of payload first.
- sin_ready  output  1  loader accepts a bit this cycle.
- busy  output  1  load in progress.
- cfg_d  output  CFG_W  active configuration to the cells.
- cfg_done  output  1  one-cycle pulse: commit succeeded.
- cfg_err  output  1  one-cycle pulse: parity mismatch, no commit.
- rb_req  input  1  readback request (READBACK_EN only).
- rb_valid  output  1  readback bit valid.
- rb_data  output  1  readback bit.

Behaviour:
- Reset: when clr is high at a clock edge:
  - state goes to IDLE.
  - cfg_d=0, shadow=0, bit counter=0, running parity=0.
  - busy=0, cfg_done=0, cfg_err=0, rb_valid=0, rb_data=0.
  - clr has priority over every other input, including mid-load and mid-readback. A partially received payload is discarded.
- States: IDLE, SHIFT, PARITY, plus RDBK when READBACK_EN is defined.
- sin_ready is decoded from the state register: 1 in SHIFT and PARITY, 0 otherwise.
- busy is 1 in SHIFT and PARITY.
- A transfer occurs at an edge where sin_valid && sin_ready. sin_valid low stalls with no state change; gaps of any length are legal.
- IDLE:
  - start=1 → SHIFT on the next edge.
  - Counter and parity are cleared.
  - Shadow keeps stale contents; every shadow bit is overwritten before commit.
- SHIFT:
  - Each transfer writes shadow[cnt] <= sin_data, XORs the bit into the running parity, and increments cnt.
  - The transfer with cnt==CFG_W-1 moves the state to PARITY.
- PARITY: on a transfer, state → IDLE.
  - If sin_data == running parity (even parity over payload plus check bit): cfg_d <= shadow and cfg_done=1 in the following cycle.
  - Otherwise: cfg_d is unchanged and cfg_err=1 in the following cycle.
  - cfg_done and cfg_err are registered, never both high, and last exactly one cycle.
  - The new cfg_d value is visible in the same cycle as cfg_done.
- Latency: start-to-first-accept is 1 cycle. Minimum load is CFG_W+2 cycles from start to cfg_done.
- start while busy or in RDBK is ignored, not queued.
- start in the same cycle that cfg_done/cfg_err is high is accepted, since state is already IDLE.
- cfg_d changes only on a successful commit or on clr. There are no intermediate glitches on the cell configuration.
- Counter width is $clog2(CFG_W), minimum 1. It never wraps during a legal load.

Optional Feature:
- Macro READBACK_EN.
- Defined:
  - In IDLE, rb_req=1 (with start=0) enters RDBK.
  - Over CFG_W consecutive cycles, rb_valid=1 and rb_data=cfg_d[k] for k=0..CFG_W-1, LSB first. There is no backpressure.
  - After the last bit, the state returns to IDLE and rb_valid drops.
  - start in IDLE has priority over rb_req. start during RDBK is ignored.
- Not defined:
  - RDBK does not exist and rb_req is ignored.
  - rb_valid and rb_data are tied 0.
  - Port list is identical in both builds.

Test Plan:
- Configure with NUM_CELLS=2 (CFG_W=8) for all scenarios.
- Good load: clr, start, payload 0xA5 sent as bits 1,0,1,0,0,1,0,1, then parity 0 → cfg_d=0xA5, cfg_done pulses 1 cycle 10 cycles after start, cfg_err=0, busy low after.
- Bad parity: after the good load, send payload 0x3C with parity 1 → cfg_err pulses 1 cycle, cfg_d stays 0xA5.
- Stalls: payload 0xFF with sin_valid toggled every other cycle, parity 0 → cfg_d=0xFF. No bit is lost or duplicated; sin_ready stays 1 throughout SHIFT.
- Reset mid-load: clr after 3 accepted bits → busy=0, cfg_d=0. A subsequent full load of 0x5A with parity 0 commits 0x5A.
- start while busy: pulse start during SHIFT → no restart. cnt continues and the payload commits correctly.
- READBACK_EN: after committing 0xA5, pulse rb_req → rb_valid high for 8 cycles with rb_data 1,0,1,0,0,1,0,1. Without the macro, rb_valid stays 0.
